// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite bus types plus the helpers the SRAM slave uses to decode
// transfer legality and byte-lane enables.
package AHB_package;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [2:0] {
    HSIZE_BYTE   = 3'b000,
    HSIZE_HALF   = 3'b001,
    HSIZE_WORD   = 3'b010,
    HSIZE_DWORD  = 3'b011,
    HSIZE_4WORD  = 3'b100,
    HSIZE_8WORD  = 3'b101,
    HSIZE_16WORD = 3'b110,
    HSIZE_32WORD = 3'b111
  } hsize_type;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_type;

  // Little-endian byte lanes touched by a transfer of the given size/offset.
  function automatic logic [3:0] lane_enables(input hsize_type size, input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << offset;
      HSIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  // A transfer is legal when it is at most a word, naturally aligned, and
  // its word index (addr[9:2]) lies inside the populated part of the region.
  function automatic logic transfer_legal(input hsize_type size, input logic [9:0] addr,
                                          input int unsigned depth);
    logic aligned;
    logic in_range;
    case (size)
      HSIZE_BYTE: aligned = 1'b1;
      HSIZE_HALF: aligned = (addr[0] == 1'b0);
      HSIZE_WORD: aligned = (addr[1:0] == 2'b00);
      default:    aligned = 1'b0;
    endcase
    in_range = (32'(addr[9:2]) < depth);
    return aligned && in_range;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM: synchronous byte-enable write, asynchronous read.
// Contents are deliberately left unreset.
module ahb_sram_array #(
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_DEPTH];

  // Commit only the enabled byte lanes; disabled lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (we && be[lane]) begin
        mem[waddr][8*lane +: 8] <= wdata[8*lane +: 8];
      end
    end
  end

  // Combinational read so a read right behind a write sees the new word.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, programmable wait
// states for OKAY transfers, and the two-cycle ERROR response for illegal
// (oversized, misaligned or out-of-range) transfers.
module ahb_sram_slave
  import AHB_package::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int MEM_DEPTH      = 256,
  parameter int WAIT_STATES    = 1
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  htrans_type                htrans,
  input  logic                      hwrite,
  input  hsize_type                 hsize,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata,
  input  logic                      hready_in,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  output logic                      hreadyout,
  output hresp_type                 hresp
);

  localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } state_type;

  state_type   state;
  logic [2:0]  wait_cnt;
  logic [9:0]  addr_q;
  logic        write_q;
  hsize_type   size_q;

  logic        accept;
  logic        legal;
  logic        mem_we;
  logic        read_final;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic [31:0] rdata_hold;

  // Region selection belongs to the decoder, so upper address bits are dropped.
  logic        unused_addr_hi;
  assign unused_addr_hi = ^haddr[AHB_ADDR_WIDTH-1:10];

  assign accept     = hsel && hready_in && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign legal      = transfer_legal(hsize, haddr[9:0], MEM_DEPTH);
  assign mem_we     = (state == ST_ACCESS) && hreadyout && write_q && !hreset;
  assign read_final = (state == ST_ACCESS) && hreadyout && !write_q;
  assign mem_be     = lane_enables(size_q, addr_q[1:0]);

  ahb_sram_array #(
    .MEM_DEPTH(MEM_DEPTH),
    .IDX_W    (IDX_W)
  ) u_array (
    .clk  (hclk),
    .we   (mem_we),
    .be   (mem_be),
    .waddr(addr_q[IDX_W+1:2]),
    .wdata(hwdata),
    .raddr(addr_q[IDX_W+1:2]),
    .rdata(mem_rdata)
  );

  // Transfer FSM: the final data-phase cycle (hreadyout=1) doubles as the
  // next address phase; otherwise wait states or ERR1->ERR2 play out.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 3'd0;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      addr_q    <= 10'd0;
      write_q   <= 1'b0;
      size_q    <= HSIZE_BYTE;
    end else if (hreadyout) begin
      if (accept) begin
        addr_q  <= haddr[9:0];
        write_q <= hwrite;
        size_q  <= hsize;
        if (legal) begin
          state     <= ST_ACCESS;
          wait_cnt  <= WAIT_INIT;
          hreadyout <= (WAIT_INIT == 3'd0);
          hresp     <= HRESP_OKAY;
        end else begin
          state     <= ST_ERR1;
          wait_cnt  <= 3'd0;
          hreadyout <= 1'b0;
          hresp     <= HRESP_ERROR;
        end
      end else begin
        state     <= ST_IDLE;
        wait_cnt  <= 3'd0;
        hreadyout <= 1'b1;
        hresp     <= HRESP_OKAY;
      end
    end else begin
      case (state)
        ST_ACCESS: begin
          hresp <= HRESP_OKAY;
          if (wait_cnt > 3'd1) begin
            wait_cnt  <= wait_cnt - 3'd1;
            hreadyout <= 1'b0;
          end else begin
            wait_cnt  <= 3'd0;
            hreadyout <= 1'b1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
        end
        default: begin
          state     <= ST_IDLE;
          wait_cnt  <= 3'd0;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Remember the last word returned so hrdata is stable between reads.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      rdata_hold <= 32'd0;
    end else if (read_final) begin
      rdata_hold <= mem_rdata;
    end else begin
      rdata_hold <= rdata_hold;
    end
  end

  // Present the live array word during a read's final cycle, else the held one.
  always_comb begin
    if (read_final) begin
      hrdata = mem_rdata;
    end else begin
      hrdata = rdata_hold;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: two instances (1 wait state / 256
// words, and 0 wait states / 64 words) driven from a vector table, with a
// scoreboard queue consumed by a data-phase monitor.
module tb_ahb_sram_slave;
  import AHB_package::*;

  localparam int WS0 = 1;
  localparam int WS1 = 0;

  typedef struct {
    logic        d;
    htrans_type  tr;
    logic        wr;
    hsize_type   sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    hresp_type   resp;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        wr;
    hresp_type   resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        hreset = 1'b0;
  logic        hsel = 1'b0;
  logic        hwrite = 1'b0;
  htrans_type  htrans = HTRANS_IDLE;
  hsize_type   hsize = HSIZE_WORD;
  logic [31:0] haddr = 32'd0;
  logic [31:0] hwdata = 32'd0;
  logic        cur = 1'b0;
  logic        mon_en = 1'b0;

  logic        hsel0, hsel1, hready_in0, hready_in1;
  logic        hreadyout0, hreadyout1;
  logic [31:0] hrdata0, hrdata1;
  hresp_type   hresp0, hresp1;
  logic        rdy_m;
  hresp_type   resp_m;
  logic [31:0] rdata_m;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  exp_t        cur_exp;
  logic        dp_active = 1'b0;
  int          low_cnt = 0;
  logic [31:0] pend_wdata = 32'd0;
  vec_t        tbl[34];

  assign hsel0      = hsel && (cur == 1'b0);
  assign hsel1      = hsel && (cur == 1'b1);
  assign hready_in0 = hreadyout0;
  assign hready_in1 = hreadyout1;
  assign rdy_m      = cur ? hreadyout1 : hreadyout0;
  assign resp_m     = cur ? hresp1 : hresp0;
  assign rdata_m    = cur ? hrdata1 : hrdata0;

  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(WS0)) dut0 (
    .hclk(clk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in0),
    .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0));

  ahb_sram_slave #(.MEM_DEPTH(64), .WAIT_STATES(WS1)) dut1 (
    .hclk(clk), .hreset(hreset), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in1),
    .hrdata(hrdata1), .hreadyout(hreadyout1), .hresp(hresp1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic d, input htrans_type tr, input logic wr,
                              input hsize_type sz, input logic [31:0] addr,
                              input logic [31:0] wdata, input hresp_type resp,
                              input logic [31:0] rdata);
    vec_t v;
    v.d = d; v.tr = tr; v.wr = wr; v.sz = sz; v.addr = addr;
    v.wdata = wdata; v.resp = resp; v.rdata = rdata;
    return v;
  endfunction

  // Data-phase monitor: pops one expectation per accepted transfer.
  always @(negedge clk) begin
    if (hreset) begin
      dp_active = 1'b0;
      low_cnt   = 0;
    end else if (mon_en) begin
      if (dp_active) begin
        if (!rdy_m) begin
          low_cnt++;
          chk("resp_wait", 32'(resp_m), 32'(cur_exp.resp));
          if (low_cnt > 16) begin
            chk("wait_bound", 32'(low_cnt), 32'(cur_exp.waits));
            dp_active = 1'b0;
          end
        end else begin
          chk("resp_final", 32'(resp_m), 32'(cur_exp.resp));
          chk("wait_cycles", 32'(low_cnt), 32'(cur_exp.waits));
          if (!cur_exp.wr && cur_exp.resp == HRESP_OKAY) begin
            chk("rdata", rdata_m, cur_exp.rdata);
          end
          dp_active = 1'b0;
        end
      end else begin
        chk("idle_ready", 32'(rdy_m), 32'd1);
        chk("idle_resp", 32'(resp_m), 32'(HRESP_OKAY));
      end
      if (rdy_m && hsel && htrans[1]) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          cur_exp   = sb.pop_front();
          dp_active = 1'b1;
          low_cnt   = 0;
        end
      end
    end
  end

  // Hold the address phase until the slave samples it (bounded).
  task automatic wait_accept();
    int   n = 0;
    logic r;
    do begin
      @(negedge clk);
      r = rdy_m;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 32);
    if (!r) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive(input htrans_type tr, input logic sel, input logic wr,
                       input hsize_type sz, input logic [31:0] addr, input logic [31:0] wd,
                       input hresp_type resp, input logic [31:0] rdata);
    exp_t e;
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = addr;
    hwdata = pend_wdata;
    if (sel && tr[1]) begin
      e.wr = wr; e.resp = resp; e.rdata = rdata;
      e.waits = (resp == HRESP_ERROR) ? 1 : (cur ? WS1 : WS0);
      sb.push_back(e);
    end
    pend_wdata = wd;
    wait_accept();
  endtask

  task automatic flush();
    drive(HTRANS_IDLE, 1'b0, 1'b0, HSIZE_WORD, 32'd0, 32'd0, HRESP_OKAY, 32'd0);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].tr, 1'b1, tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wdata,
            tbl[i].resp, tbl[i].rdata);
    end
    flush();
  endtask

  initial begin
    // instance 0: WAIT_STATES=1, MEM_DEPTH=256, transfers back-to-back
    tbl[0]  = mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD,  32'h0000_0010, 32'hDEAD_BEEF, HRESP_OKAY,  32'h0);
    tbl[1]  = mk(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_0010, 32'h0,         HRESP_OKAY,  32'hDEAD_BEEF);
    tbl[2]  = mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD,  32'h0000_0010, 32'h1122_3344, HRESP_OKAY,  32'h0);
    tbl[3]  = mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE,  32'h0000_0013, 32'hAAAA_AAAA, HRESP_OKAY,  32'h0);
    tbl[4]  = mk(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_0010, 32'h0,         HRESP_OKAY,  32'hAA22_3344);
    tbl[5]  = mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD,  32'h0000_0012, 32'h5555_5555, HRESP_ERROR, 32'h0);
    tbl[6]  = mk(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_0010, 32'h0,         HRESP_OKAY,  32'hAA22_3344);
    tbl[7]  = mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_HALF,  32'h0000_0011, 32'h6666_6666, HRESP_ERROR, 32'h0);
    tbl[8]  = mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_HALF,  32'h0000_0012, 32'h7777_BEEF, HRESP_OKAY,  32'h0);
    tbl[9]  = mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE,  32'h0000_0011, 32'h0000_CC00, HRESP_OKAY,  32'h0);
    tbl[10] = mk(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_0010, 32'h0,         HRESP_OKAY,  32'h7777_CC44);
    tbl[11] = mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_DWORD, 32'h0000_0018, 32'h1234_1234, HRESP_ERROR, 32'h0);
    tbl[12] = mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD,  32'hFFFF_F024, 32'hCAFE_F00D, HRESP_OKAY,  32'h0);
    tbl[13] = mk(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_0024, 32'h0,         HRESP_OKAY,  32'hCAFE_F00D);
    tbl[14] = mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD,  32'h0000_03FC, 32'h0BAD_C0DE, HRESP_OKAY,  32'h0);
    tbl[15] = mk(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_03FC, 32'h0,         HRESP_OKAY,  32'h0BAD_C0DE);
    tbl[16] = mk(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_BYTE,  32'h0000_0025, 32'h0,         HRESP_OKAY,  32'hCAFE_F00D);
    tbl[17] = mk(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_0026, 32'h0,         HRESP_ERROR, 32'h0);
    tbl[18] = mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD,  32'h0000_0020, 32'h1234_5678, HRESP_OKAY,  32'h0);
    tbl[19] = mk(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_HALF,  32'h0000_0012, 32'h0,         HRESP_OKAY,  32'h7777_CC44);
    // instance 1: WAIT_STATES=0, MEM_DEPTH=64, one transfer per cycle
    tbl[20] = mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD,  32'h0000_0000, 32'hA0A0_A0A0, HRESP_OKAY,  32'h0);
    tbl[21] = mk(1'b1, HTRANS_SEQ,    1'b1, HSIZE_WORD,  32'h0000_0004, 32'hA1A1_A1A1, HRESP_OKAY,  32'h0);
    tbl[22] = mk(1'b1, HTRANS_SEQ,    1'b1, HSIZE_WORD,  32'h0000_0008, 32'hA2A2_A2A2, HRESP_OKAY,  32'h0);
    tbl[23] = mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_0000, 32'h0,         HRESP_OKAY,  32'hA0A0_A0A0);
    tbl[24] = mk(1'b1, HTRANS_SEQ,    1'b0, HSIZE_WORD,  32'h0000_0004, 32'h0,         HRESP_OKAY,  32'hA1A1_A1A1);
    tbl[25] = mk(1'b1, HTRANS_SEQ,    1'b0, HSIZE_WORD,  32'h0000_0008, 32'h0,         HRESP_OKAY,  32'hA2A2_A2A2);
    tbl[26] = mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD,  32'h0000_00FC, 32'h0F0F_0F0F, HRESP_OKAY,  32'h0);
    tbl[27] = mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_00FC, 32'h0,         HRESP_OKAY,  32'h0F0F_0F0F);
    tbl[28] = mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD,  32'h0000_0100, 32'hDEAD_DEAD, HRESP_ERROR, 32'h0);
    tbl[29] = mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_0000, 32'h0,         HRESP_OKAY,  32'hA0A0_A0A0);
    tbl[30] = mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_0100, 32'h0,         HRESP_ERROR, 32'h0);
    tbl[31] = mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE,  32'h0000_0005, 32'h0000_5A00, HRESP_OKAY,  32'h0);
    tbl[32] = mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF,  32'h0000_0006, 32'hBBBB_1111, HRESP_OKAY,  32'h0);
    tbl[33] = mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h0000_0004, 32'h0,         HRESP_OKAY,  32'hBBBB_5AA1);

    // reset values on both instances
    #2 hreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", 32'(hreadyout0), 32'd1);
    chk("rst_resp0",  32'(hresp0), 32'(HRESP_OKAY));
    chk("rst_rdata0", hrdata0, 32'd0);
    chk("rst_ready1", 32'(hreadyout1), 32'd1);
    chk("rst_rdata1", hrdata1, 32'd0);
    hreset = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    cur = 1'b0;
    run_table(0, 19);
    repeat (3) @(posedge clk);
    #1;
    chk("rdata_hold", hrdata0, 32'h7777_CC44);

    // BUSY with hsel=1 and NONSEQ with hsel=0: zero-wait OKAY, no write
    drive(HTRANS_BUSY, 1'b1, 1'b1, HSIZE_WORD, 32'h0000_0010, 32'hFFFF_FFFF, HRESP_OKAY, 32'h0);
    chk("busy_ready", 32'(hreadyout0), 32'd1);
    chk("busy_resp",  32'(hresp0), 32'(HRESP_OKAY));
    drive(HTRANS_NONSEQ, 1'b0, 1'b1, HSIZE_WORD, 32'h0000_0010, 32'hEEEE_EEEE, HRESP_OKAY, 32'h0);
    chk("nosel_ready", 32'(hreadyout0), 32'd1);
    drive(HTRANS_NONSEQ, 1'b1, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0, HRESP_OKAY, 32'h7777_CC44);
    flush();

    // reset during the wait cycle of a write to 0x20
    mon_en = 1'b0;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = 32'h0000_0020;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h9999_9999;
    chk("rst_mid_wait", 32'(hreadyout0), 32'd0);
    hreset = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(hreadyout0), 32'd1);
    chk("rst_mid_resp",  32'(hresp0), 32'(HRESP_OKAY));
    chk("rst_mid_rdata", hrdata0, 32'd0);
    @(posedge clk);
    #1;
    hreset = 1'b0;
    pend_wdata = 32'd0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(HTRANS_NONSEQ, 1'b1, 1'b0, HSIZE_WORD, 32'h0000_0020, 32'h0, HRESP_OKAY, 32'h1234_5678);
    flush();

    cur = 1'b1;
    run_table(20, 33);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("dp_closed", 32'(dp_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
